// File: rtl/kv_pkg.sv
// Shared types and the per-way key hash for the hashed key/value engine.
package kv_pkg;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_CREDIT = 2'd2,
    OP_DEBIT  = 2'd3
  } kv_op_e;

  typedef enum logic [2:0] {
    ST_OK         = 3'd0,
    ST_NOT_FOUND  = 3'd1,
    ST_TABLE_FULL = 3'd2,
    ST_VALUE_FULL = 3'd3,
    ST_UNDERFLOW  = 3'd4,
    ST_OVERFLOW   = 3'd5
  } kv_status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_KEY = 3'd1,
    S_CMP    = 3'd2,
    S_RD_VAL = 3'd3,
    S_EXEC   = 3'd4,
    S_RESP   = 3'd5
  } kv_state_e;

  // Upper bounds the hash helper is written for (KEY_W <= 64, ADDR_BITS <= 16).
  localparam int HASH_MAX_KEY_W     = 64;
  localparam int HASH_MAX_ADDR_BITS = 16;
  localparam int HASH_KEY_IDX_W     = $clog2(HASH_MAX_KEY_W);
  localparam int HASH_ADDR_IDX_W    = $clog2(HASH_MAX_ADDR_BITS);

  // Way hash: rotate the key left by (7*way) mod key_w, then fold it by XOR
  // of consecutive addr_bits-wide slices (top slice zero-padded).
  // Bit b of the rotated key lands in bit (b mod addr_bits) of the index.
  function automatic logic [HASH_MAX_ADDR_BITS-1:0] kv_hash(
    input logic [HASH_MAX_KEY_W-1:0] key,
    input int                        key_w,
    input int                        addr_bits,
    input int                        way
  );
    logic [HASH_MAX_KEY_W-1:0]     rot;
    logic [HASH_MAX_ADDR_BITS-1:0] acc;
    int                            sh;
    sh  = (7 * way) % key_w;
    rot = '0;
    acc = '0;
    for (int b = 0; b < HASH_MAX_KEY_W; b++) begin
      if (b < key_w) rot[b] = key[HASH_KEY_IDX_W'((b - sh + key_w) % key_w)];
    end
    for (int b = 0; b < HASH_MAX_KEY_W; b++) begin
      if (b < key_w) acc[HASH_ADDR_IDX_W'(b % addr_bits)] ^= rot[b];
    end
    return acc;
  endfunction

endpackage

// File: rtl/kv_way_table.sv
// One hash way: valid flops, key and value-address RAM, one write port and
// a registered read of the entry at i_rd_idx.
module kv_way_table
  import kv_pkg::*;
#(
  parameter int KEY_W         = 32,
  parameter int ADDR_BITS     = 9,
  parameter int VAL_ADDR_BITS = 9
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_BITS-1:0]     i_rd_idx,
  output logic                     o_rd_valid,
  output logic [KEY_W-1:0]         o_rd_key,
  output logic [VAL_ADDR_BITS-1:0] o_rd_val_addr,
  input  logic                     i_wr_en,
  input  logic [ADDR_BITS-1:0]     i_wr_idx,
  input  logic [KEY_W-1:0]         i_wr_key,
  input  logic [VAL_ADDR_BITS-1:0] i_wr_val_addr
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DEPTH-1:0]         r_valid;
  logic                     r_rd_valid;
  logic [KEY_W-1:0]         r_key_mem   [DEPTH];
  logic [VAL_ADDR_BITS-1:0] r_vaddr_mem [DEPTH];
  logic [KEY_W-1:0]         r_rd_key;
  logic [VAL_ADDR_BITS-1:0] r_rd_vaddr;

  // Valid bits are real flops so reset empties the table in one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
      r_rd_valid <= r_valid[i_rd_idx];
    end
  end

  // Key / value-address storage: plain synchronous-read RAM, no reset.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_key_mem[i_wr_idx]   <= i_wr_key;
      r_vaddr_mem[i_wr_idx] <= i_wr_val_addr;
    end
    r_rd_key   <= r_key_mem[i_rd_idx];
    r_rd_vaddr <= r_vaddr_mem[i_rd_idx];
  end

  assign o_rd_valid    = r_rd_valid;
  assign o_rd_key      = r_rd_key;
  assign o_rd_val_addr = r_rd_vaddr;

endmodule

// File: rtl/kv_hash_engine.sv
// Multi-way hashed key table in front of a bump-allocated value RAM.
// Handshake: a request is taken on the rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so req_valid while
// busy is ignored. resp_valid pulses for one cycle; resp_* hold until the
// next response.
module kv_hash_engine
  import kv_pkg::*;
#(
  parameter int KEY_W         = 32,
  parameter int VAL_W         = 32,
  parameter int ADDR_BITS     = 9,
  parameter int WAYS          = 2,
  parameter int VAL_ADDR_BITS = 9
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [KEY_W-1:0]         req_key,
  input  logic [VAL_W-1:0]         req_value,
  output logic                     resp_valid,
  output logic [2:0]               resp_status,
  output logic [VAL_W-1:0]         resp_value,
  output logic [VAL_ADDR_BITS-1:0] resp_val_addr,
  output kv_state_e                dbg_state
);

  localparam int VAL_DEPTH = 1 << VAL_ADDR_BITS;
  localparam int CNT_W     = VAL_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VAL_DEPTH);
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  kv_state_e r_state, w_next;

  // Latched request
  kv_op_e                   r_op;
  logic [KEY_W-1:0]         r_key;
  logic [VAL_W-1:0]         r_amt;

  // Lookup result captured in CMP
  logic                     r_hit, w_hit;
  logic [VAL_ADDR_BITS-1:0] r_hit_vaddr, w_hit_vaddr;
  logic                     r_free_ok, w_free_ok;
  logic [WAY_W-1:0]         r_free_way, w_free_way;

  // Value RAM and allocator
  logic [VAL_W-1:0]         r_val_mem [VAL_DEPTH];
  logic [VAL_W-1:0]         r_val_rd;
  logic [CNT_W-1:0]         r_alloc_cnt;
  logic [VAL_ADDR_BITS-1:0] w_alloc_ptr;

  // EXEC results and write controls
  kv_status_e               w_res_status, r_res_status;
  logic [VAL_W-1:0]         w_res_value, r_res_value;
  logic [VAL_ADDR_BITS-1:0] w_res_vaddr, r_res_vaddr;
  logic                     w_val_we;
  logic [VAL_ADDR_BITS-1:0] w_val_waddr;
  logic [VAL_W-1:0]         w_val_wdata;
  logic                     w_do_alloc;
  logic [VAL_W:0]           w_sum;
  logic [VAL_W-1:0]         w_diff;

  // Response output registers
  logic                     r_resp_valid;
  kv_status_e               r_resp_status;
  logic [VAL_W-1:0]         r_resp_value;
  logic [VAL_ADDR_BITS-1:0] r_resp_vaddr;

  // Way interface
  logic [ADDR_BITS-1:0]     w_idx      [WAYS];
  logic [WAYS-1:0]          w_rd_valid;
  logic [KEY_W-1:0]         w_rd_key   [WAYS];
  logic [VAL_ADDR_BITS-1:0] w_rd_vaddr [WAYS];
  logic [WAYS-1:0]          w_key_we;

  assign w_alloc_ptr = r_alloc_cnt[VAL_ADDR_BITS-1:0];

  // r_key is stable from RD_KEY through EXEC, so the same index serves the
  // read and the later key write.
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_idx[g] = ADDR_BITS'(kv_hash(HASH_MAX_KEY_W'(r_key), KEY_W, ADDR_BITS, g));

    kv_way_table #(
      .KEY_W         (KEY_W),
      .ADDR_BITS     (ADDR_BITS),
      .VAL_ADDR_BITS (VAL_ADDR_BITS)
    ) u_way (
      .clock         (clock),
      .reset_n       (reset_n),
      .i_rd_idx      (w_idx[g]),
      .o_rd_valid    (w_rd_valid[g]),
      .o_rd_key      (w_rd_key[g]),
      .o_rd_val_addr (w_rd_vaddr[g]),
      .i_wr_en       (w_key_we[g]),
      .i_wr_idx      (w_idx[g]),
      .i_wr_key      (r_key),
      .i_wr_val_addr (w_alloc_ptr)
    );
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM next state: fixed six-cycle walk once a request is taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_RD_KEY;
      S_RD_KEY: w_next = S_CMP;
      S_CMP:    w_next = S_RD_VAL;
      S_RD_VAL: w_next = S_EXEC;
      S_EXEC:   w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Way compare: lowest valid matching way is the hit, lowest invalid way is
  // the insert candidate (scan from the top so the lowest index wins)
  always_comb begin
    w_hit       = 1'b0;
    w_hit_vaddr = '0;
    w_free_ok   = 1'b0;
    w_free_way  = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_rd_valid[i] && (w_rd_key[i] == r_key)) begin
        w_hit       = 1'b1;
        w_hit_vaddr = w_rd_vaddr[i];
      end
      if (!w_rd_valid[i]) begin
        w_free_ok  = 1'b1;
        w_free_way = WAY_W'(i);
      end
    end
  end

  // Operation result and write controls; writes only fire in EXEC
  always_comb begin
    w_res_status = ST_OK;
    w_res_value  = '0;
    w_res_vaddr  = '0;
    w_val_we     = 1'b0;
    w_val_waddr  = r_hit_vaddr;
    w_val_wdata  = r_amt;
    w_do_alloc   = 1'b0;
    w_sum        = {1'b0, r_val_rd} + {1'b0, r_amt};
    w_diff       = r_val_rd - r_amt;
    if (!r_hit && (r_op != OP_INSERT)) begin
      w_res_status = ST_NOT_FOUND;
    end else begin
      case (r_op)
        OP_SEARCH: begin
          w_res_value = r_val_rd;
          w_res_vaddr = r_hit_vaddr;
        end
        OP_INSERT: begin
          if (r_hit) begin
            w_val_we    = 1'b1;
            w_res_value = r_amt;
            w_res_vaddr = r_hit_vaddr;
          end else if (!r_free_ok) begin
            w_res_status = ST_TABLE_FULL;
          end else if (r_alloc_cnt == CNT_FULL) begin
            w_res_status = ST_VALUE_FULL;
          end else begin
            w_do_alloc  = 1'b1;
            w_val_we    = 1'b1;
            w_val_waddr = w_alloc_ptr;
            w_res_value = r_amt;
            w_res_vaddr = w_alloc_ptr;
          end
        end
        OP_CREDIT: begin
          w_res_vaddr = r_hit_vaddr;
          if (w_sum[VAL_W]) begin
            w_res_status = ST_OVERFLOW;
            w_res_value  = r_val_rd;
          end else begin
            w_val_we    = 1'b1;
            w_val_wdata = w_sum[VAL_W-1:0];
            w_res_value = w_sum[VAL_W-1:0];
          end
        end
        OP_DEBIT: begin
          w_res_vaddr = r_hit_vaddr;
          if (r_amt > r_val_rd) begin
            w_res_status = ST_UNDERFLOW;
            w_res_value  = r_val_rd;
          end else begin
            w_val_we    = 1'b1;
            w_val_wdata = w_diff;
            w_res_value = w_diff;
          end
        end
        default: ;
      endcase
    end
    if (r_state != S_EXEC) begin
      w_val_we   = 1'b0;
      w_do_alloc = 1'b0;
    end
  end

  // Key write goes to the chosen free way only when a new slot is allocated
  always_comb begin
    w_key_we = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_key_we[i] = w_do_alloc && (r_free_way == WAY_W'(i));
    end
  end

  // Value RAM: written in EXEC, read at the hit address in RD_VAL
  always_ff @(posedge clock) begin
    if (w_val_we) r_val_mem[w_val_waddr] <= w_val_wdata;
    if (r_state == S_RD_VAL) r_val_rd <= r_val_mem[r_hit_vaddr];
  end

  // Request latch, lookup capture, allocator and response registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op          <= OP_SEARCH;
      r_key         <= '0;
      r_amt         <= '0;
      r_hit         <= 1'b0;
      r_hit_vaddr   <= '0;
      r_free_ok     <= 1'b0;
      r_free_way    <= '0;
      r_alloc_cnt   <= '0;
      r_res_status  <= ST_OK;
      r_res_value   <= '0;
      r_res_vaddr   <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_status <= ST_OK;
      r_resp_value  <= '0;
      r_resp_vaddr  <= '0;
    end else begin
      if ((r_state == S_IDLE) && req_valid) begin
        r_op  <= kv_op_e'(req_op);
        r_key <= req_key;
        r_amt <= req_value;
      end
      if (r_state == S_CMP) begin
        r_hit       <= w_hit;
        r_hit_vaddr <= w_hit_vaddr;
        r_free_ok   <= w_free_ok;
        r_free_way  <= w_free_way;
      end
      if (w_do_alloc) r_alloc_cnt <= r_alloc_cnt + CNT_W'(1);
      if (r_state == S_EXEC) begin
        r_res_status <= w_res_status;
        r_res_value  <= w_res_value;
        r_res_vaddr  <= w_res_vaddr;
      end
      r_resp_valid <= (r_state == S_RESP);
      if (r_state == S_RESP) begin
        r_resp_status <= r_res_status;
        r_resp_value  <= r_res_value;
        r_resp_vaddr  <= r_res_vaddr;
      end
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = r_resp_valid;
  assign resp_status   = r_resp_status;
  assign resp_value    = r_resp_value;
  assign resp_val_addr = r_resp_vaddr;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_kv_hash_engine.sv
// Bench for kv_hash_engine: a default instance, a single-way instance and a
// four-slot value RAM instance share clock, reset and request buses; each has
// its own req_valid and response outputs.
module tb_kv_hash_engine;
  import kv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic [2:0]  req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_key;
  logic [31:0] req_value;

  logic        rdy   [3];
  logic        rv    [3];
  logic [2:0]  st    [3];
  logic [31:0] rval  [3];
  logic [8:0]  raddr [3];
  logic [8:0]  addr0, addr1;
  logic [1:0]  addr2;
  kv_state_e   dbg0, dbg1, dbg2;

  assign raddr[0] = addr0;
  assign raddr[1] = addr1;
  assign raddr[2] = {7'd0, addr2};

  kv_hash_engine u_main (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(rdy[0]),
    .req_op(req_op), .req_key(req_key), .req_value(req_value), .resp_valid(rv[0]),
    .resp_status(st[0]), .resp_value(rval[0]), .resp_val_addr(addr0), .dbg_state(dbg0)
  );

  kv_hash_engine #(.WAYS(1)) u_w1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(rdy[1]),
    .req_op(req_op), .req_key(req_key), .req_value(req_value), .resp_valid(rv[1]),
    .resp_status(st[1]), .resp_value(rval[1]), .resp_val_addr(addr1), .dbg_state(dbg1)
  );

  kv_hash_engine #(.VAL_ADDR_BITS(2)) u_v2 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(rdy[2]),
    .req_op(req_op), .req_key(req_key), .req_value(req_value), .resp_valid(rv[2]),
    .resp_status(st[2]), .resp_value(rval[2]), .resp_val_addr(addr2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  typedef struct {
    logic [1:0]  inst;
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] val;
    logic [2:0]  exp_status;
    logic [31:0] exp_value;
    logic [8:0]  exp_addr;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [1:0] inst, input logic [1:0] op,
                              input logic [31:0] key, input logic [31:0] val,
                              input logic [2:0] es, input logic [31:0] ev,
                              input logic [8:0] ea, input string name);
    vec_t v;
    v.inst = inst; v.op = op; v.key = key; v.val = val;
    v.exp_status = es; v.exp_value = ev; v.exp_addr = ea; v.name = name;
    vq.push_back(v);
  endfunction

  // ---------------- driver ----------------
  // Issue one request, check the 6-cycle turnaround and ready behaviour,
  // and return the response fields.
  task automatic do_req(input logic [1:0] inst, input logic [1:0] op,
                        input logic [31:0] key, input logic [31:0] val, input string name,
                        output logic [2:0] o_st, output logic [31:0] o_val,
                        output logic [8:0] o_addr);
    int lat;
    logic busy_rdy;
    @(negedge clock);
    chk({name, "/ready_idle"}, 32'(rdy[inst]), 32'd1);
    req_op = op; req_key = key; req_value = val; req_valid[inst] = 1'b1;
    @(posedge clock);
    #1 req_valid[inst] = 1'b0;
    lat = -1;
    busy_rdy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (rv[inst]) begin
        lat = k;
        break;
      end
      if (rdy[inst]) busy_rdy = 1'b1;
    end
    chk({name, "/latency"}, 32'(lat), 32'd6);
    chk({name, "/ready_low_busy"}, 32'(busy_rdy), 32'd0);
    chk({name, "/ready_at_resp"}, 32'(rdy[inst]), 32'd1);
    o_st = st[inst]; o_val = rval[inst]; o_addr = raddr[inst];
    @(negedge clock);
    chk({name, "/strobe_one_cycle"}, 32'(rv[inst]), 32'd0);
  endtask

  // Global time limit so the run always ends
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [2:0]  s;
    logic [31:0] v;
    logic [8:0]  a;
    int          lat;
    logic        seen;

    // Table: inst 0 = default, 1 = WAYS=1, 2 = VAL_ADDR_BITS=2
    add(0, OP_SEARCH, 279,  0,            ST_NOT_FOUND,  0,            0, "srch_empty");
    add(0, OP_INSERT, 279,  7623,         ST_OK,         7623,         0, "ins_279");
    add(0, OP_INSERT, 524,  3423,         ST_OK,         3423,         1, "ins_524");
    add(0, OP_SEARCH, 524,  0,            ST_OK,         3423,         1, "srch_524");
    add(0, OP_INSERT, 279,  100,          ST_OK,         100,          0, "ins_279_again");
    add(0, OP_SEARCH, 279,  0,            ST_OK,         100,          0, "srch_279");
    add(0, OP_INSERT, 1000, 55,           ST_OK,         55,           2, "ins_1000");
    add(0, OP_CREDIT, 279,  50,           ST_OK,         150,          0, "credit_50");
    add(0, OP_DEBIT,  279,  200,          ST_UNDERFLOW,  150,          0, "debit_under");
    add(0, OP_CREDIT, 279,  32'hFFFFFFFF, ST_OVERFLOW,   150,          0, "credit_over");
    add(0, OP_DEBIT,  279,  150,          ST_OK,         0,            0, "debit_exact");
    add(0, OP_CREDIT, 4242, 5,            ST_NOT_FOUND,  0,            0, "credit_miss");
    add(0, OP_DEBIT,  4242, 5,            ST_NOT_FOUND,  0,            0, "debit_miss");
    add(0, OP_SEARCH, 279,  0,            ST_OK,         0,            0, "srch_zero");
    add(0, OP_CREDIT, 524,  32'hFFFFF2A0, ST_OK,         32'hFFFFFFFF, 1, "credit_to_max");
    add(1, OP_INSERT, 279,  1,            ST_OK,         1,            0, "w1_ins_279");
    add(1, OP_INSERT, 790,  2,            ST_TABLE_FULL, 0,            0, "w1_ins_790");
    add(1, OP_SEARCH, 790,  0,            ST_NOT_FOUND,  0,            0, "w1_srch_790");
    add(1, OP_SEARCH, 279,  0,            ST_OK,         1,            0, "w1_srch_279");
    add(2, OP_INSERT, 1,    10,           ST_OK,         10,           0, "v2_ins_1");
    add(2, OP_INSERT, 2,    11,           ST_OK,         11,           1, "v2_ins_2");
    add(2, OP_INSERT, 3,    12,           ST_OK,         12,           2, "v2_ins_3");
    add(2, OP_INSERT, 4,    13,           ST_OK,         13,           3, "v2_ins_4");
    add(2, OP_INSERT, 5,    14,           ST_VALUE_FULL, 0,            0, "v2_ins_5_full");
    add(2, OP_INSERT, 2,    99,           ST_OK,         99,           1, "v2_ins_2_hit");
    add(2, OP_SEARCH, 5,    0,            ST_NOT_FOUND,  0,            0, "v2_srch_5");

    reset_n = 1'b0; req_valid = '0; req_op = '0; req_key = '0; req_value = '0;
    repeat (3) @(negedge clock);
    chk("reset/ready", 32'(rdy[0]), 32'd1);
    chk("reset/resp_valid", 32'(rv[0]), 32'd0);
    chk("reset/status", 32'(st[0]), 32'd0);
    chk("reset/value", rval[0], 32'd0);
    chk("reset/addr", 32'(raddr[0]), 32'd0);
    chk("reset/state", 32'(dbg0), 32'(S_IDLE));
    reset_n = 1'b1;

    foreach (vq[i]) begin
      do_req(vq[i].inst, vq[i].op, vq[i].key, vq[i].val, vq[i].name, s, v, a);
      chk({vq[i].name, "/status"}, 32'(s), 32'(vq[i].exp_status));
      chk({vq[i].name, "/value"}, v, vq[i].exp_value);
      chk({vq[i].name, "/addr"}, 32'(a), 32'(vq[i].exp_addr));
    end

    // Back-to-back: valid held high, second request taken at edge t+6 and
    // must see the insert written by the first
    @(negedge clock);
    req_op = OP_INSERT; req_key = 4242; req_value = 9; req_valid[0] = 1'b1;
    @(posedge clock);
    #1 req_op = OP_SEARCH; req_value = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (rv[0]) begin lat = k; break; end
    end
    chk("b2b_ins/latency", 32'(lat), 32'd6);
    chk("b2b_ins/status", 32'(st[0]), 32'(ST_OK));
    chk("b2b_ins/value", rval[0], 32'd9);
    chk("b2b_ins/addr", 32'(raddr[0]), 32'd3);
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (rv[0]) begin lat = k; break; end
    end
    chk("b2b_srch/latency", 32'(lat), 32'd6);
    chk("b2b_srch/status", 32'(st[0]), 32'(ST_OK));
    chk("b2b_srch/value", rval[0], 32'd9);
    chk("b2b_srch/addr", 32'(raddr[0]), 32'd3);

    // Request pulsed while busy must be dropped, not queued
    @(negedge clock);
    req_op = OP_SEARCH; req_key = 279; req_value = 0; req_valid[0] = 1'b1;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 2) begin
        req_op = OP_INSERT; req_key = 777; req_value = 5; req_valid[0] = 1'b1;
      end
      if (k == 4) req_valid[0] = 1'b0;
      if (rv[0]) begin lat = k; break; end
    end
    chk("busy_ign/latency", 32'(lat), 32'd6);
    chk("busy_ign/status", 32'(st[0]), 32'(ST_OK));
    chk("busy_ign/value", rval[0], 32'd0);
    do_req(0, OP_SEARCH, 777, 0, "busy_ign_srch", s, v, a);
    chk("busy_ign_srch/status", 32'(s), 32'(ST_NOT_FOUND));

    // Reset during EXEC: no response, write dropped, table and allocator cleared
    @(negedge clock);
    req_op = OP_INSERT; req_key = 888; req_value = 1; req_valid[0] = 1'b1;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    repeat (4) @(negedge clock);
    chk("midrst/in_exec", 32'(dbg0), 32'(S_EXEC));
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (rv[0]) seen = 1'b1;
    end
    chk("midrst/no_resp", 32'(seen), 32'd0);
    chk("midrst/ready", 32'(rdy[0]), 32'd1);
    chk("midrst/status", 32'(st[0]), 32'd0);
    chk("midrst/value", rval[0], 32'd0);
    chk("midrst/addr", 32'(raddr[0]), 32'd0);
    do_req(0, OP_SEARCH, 888, 0, "midrst_srch_888", s, v, a);
    chk("midrst_srch_888/status", 32'(s), 32'(ST_NOT_FOUND));
    chk("midrst_srch_888/value", v, 32'd0);
    do_req(0, OP_SEARCH, 279, 0, "midrst_srch_279", s, v, a);
    chk("midrst_srch_279/status", 32'(s), 32'(ST_NOT_FOUND));
    do_req(0, OP_INSERT, 31, 5, "midrst_ins_31", s, v, a);
    chk("midrst_ins_31/status", 32'(s), 32'(ST_OK));
    chk("midrst_ins_31/value", v, 32'd5);
    chk("midrst_ins_31/addr", 32'(a), 32'd0);
    chk("end/w1_state", 32'(dbg1), 32'(S_IDLE));
    chk("end/v2_state", 32'(dbg2), 32'(S_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kv_hash_engine.md
# kv_hash_engine

Parametrised successor to the single-op key/value BRAM store. A multi-way hashed key table maps keys to value-RAM addresses, with a bump allocator for the value RAM. The block accepts search, insert, credit and debit requests over a valid/ready handshake and answers with a status-coded response after a fixed latency. It sits between the transaction front-end and the ledger value memory.

## Interface
- KEY_W, 32, key width in bits
- VAL_W, 32, value width in bits
- ADDR_BITS, 9, index width per way; each way holds 2^ADDR_BITS entries
- WAYS, 2, number of hash ways (1..4)
- VAL_ADDR_BITS, 9, value RAM address width; 2^VAL_ADDR_BITS slots
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine idle, request accepted on valid&&ready
- req_op  in  2  0 SEARCH, 1 INSERT, 2 CREDIT, 3 DEBIT
- req_key  in  KEY_W  key
- req_value  in  VAL_W  insert value or transact amount
- resp_valid  out  1  one-cycle response strobe
- resp_status  out  3  0 OK, 1 NOT_FOUND, 2 TABLE_FULL, 3 VALUE_FULL, 4 UNDERFLOW, 5 OVERFLOW
- resp_value  out  VAL_W  result value
- resp_val_addr  out  VAL_ADDR_BITS  value slot used

## Operation
- Hash for way i: rotate the key left by (7*i) mod KEY_W. XOR all consecutive ADDR_BITS-bit slices, zero-padding the top slice. The result is idx_i.
- Each way entry holds {valid, key, val_addr}. Valid bits are flops cleared by reset; key/val_addr live in synchronous-read RAM.
- The FSM runs IDLE → RD_KEY → CMP → RD_VAL → EXEC → RESP → IDLE.
  - IDLE: req_ready=1; the request is latched on acceptance.
  - RD_KEY: present idx_i to all ways.
  - CMP: hit = lowest way with valid && key match. For an INSERT miss, choose the lowest invalid way.
  - RD_VAL: read the value RAM at the hit val_addr.
  - EXEC: compute the result and perform all writes.
  - RESP: resp_valid=1.
- SEARCH: on a hit, OK with the stored value. On a miss, NOT_FOUND with value 0 and addr 0.
- INSERT, hit: overwrite the value at the existing val_addr; OK; no allocation.
- INSERT, miss:
  - No invalid way → TABLE_FULL, no writes.
  - Allocator count == 2^VAL_ADDR_BITS → VALUE_FULL, no writes.
  - Otherwise write the key entry with val_addr=alloc_ptr, write the value, increment alloc_ptr; OK.
- CREDIT: sum computed VAL_W+1 bits wide. A carry gives OVERFLOW with no write and resp_value = old value. Otherwise write the sum; OK with the new value.
- DEBIT: amount > balance gives UNDERFLOW with no write and resp_value = old value. Otherwise write the difference; OK.
- CREDIT/DEBIT on a miss: NOT_FOUND, no writes.
- Value slots are never reclaimed. A key is present in at most one way by construction.

## Timing
- Fixed latency: request accepted at edge t; resp_valid is high for exactly the cycle after edge t+5; req_ready is high again from edge t+6.
- req_ready is low in every non-IDLE state; req_valid during busy is ignored and not queued.
- resp_* outputs hold their values until the next response; only resp_valid pulses.
- Back-to-back requests: one per 6 cycles; a write in EXEC is visible to the next request.
- Reset values: req_ready=1, resp_valid=0, resp_status=0, resp_value=0, resp_val_addr=0, all valid bits 0, alloc_ptr=0, FSM=IDLE.
- Reset mid-operation: the FSM aborts to IDLE, no response is issued, and a pending EXEC write is dropped.

## Structure
- Package kv_pkg holds:
  - op and status enums;
  - the hash function, a function of KEY_W, ADDR_BITS and the way number.
- Sub-module kv_way_table, instantiated WAYS times: key/val_addr RAM, valid flops, a single write port, and a registered read.
- The value RAM and allocator stay in the top level.

## Test plan
- After reset: SEARCH key 279 → NOT_FOUND, value 0, 6-cycle turnaround.
- INSERT 279/7623, then INSERT 524/3423 → OK at addrs 0 and 1. SEARCH 524 → 3423.
- INSERT 279/100 (existing key) → OK at addr 0 with no allocation. The next new key gets addr 2.
- CREDIT 279 by 50 → 150. DEBIT 279 by 200 → UNDERFLOW, value 150. CREDIT 279 by 2^32-1 → OVERFLOW, value 150.
- With WAYS=1: INSERT 279, then INSERT 790 (same idx 279) → TABLE_FULL. SEARCH 790 → NOT_FOUND.
- With VAL_ADDR_BITS=2: the fifth distinct insert → VALUE_FULL. Assert reset_n mid-request → no resp_valid, and a subsequent SEARCH → NOT_FOUND.
